cci_rd_arbiter: RTL
===================

// Module: cci_rd_arbiter
// PURPOSE
// - Shares CCI TX channel 0 (read requests) among NUM_REQ AFU-side requesters using round-robin arbitration.
// - Tags each issued read with a free tag in the mdata field, then routes the RX channel 0 read response back to its requester.
// - Sits between the AFU read engines and the CCI TX0/RX0 ports. The warnings monitor watches the same ports.
// PARAMETERS
// - NUM_REQ       4    number of requesters, 2..8
// - MAX_OUTST     16   outstanding read tags; power of 2, 2..64
// - TX_HDR_WIDTH  61   CCI TX header width
// - RX_HDR_WIDTH  18   CCI RX header width
// - DATA_WIDTH    512  cache-line data width
// - CLADDR_WIDTH  32   cache-line address width
// - RD_REQ_TYPE   4'h4 request type placed in tx header [55:52] (RdLine)
// PORTS
// - clk             in   1                      clock
// - reset           in   1                      synchronous, active-high reset
// - req_valid       in   NUM_REQ                per-requester read request
// - req_addr        in   NUM_REQ*CLADDR_WIDTH   per-requester cache-line address; requester i uses slice i
// - req_ready       out  NUM_REQ                one-hot grant; handshake completes on valid&ready
// - tx_c0_almostfull in  1                      CCI TX0 backpressure
// - tx_c0_header    out  TX_HDR_WIDTH           issued read header
// - tx_c0_rdvalid   out  1                      issued read strobe
// - rx_c0_header    in   RX_HDR_WIDTH           response header; mdata in [13:0]
// - rx_c0_data      in   DATA_WIDTH             response data
// - rx_c0_rdvalid   in   1                      read response strobe; cfg and write responses are ignored
// - rsp_valid       out  NUM_REQ                one-hot response strobe
// - rsp_addr        out  CLADDR_WIDTH           address echoed from the tag table
// - rsp_data        out  DATA_WIDTH             response data, shared by all requesters
// - outst_cnt       out  $clog2(MAX_OUTST)+1    number of live tags
// - err_unexp_rsp   out  1                      1-cycle pulse for a response whose tag is not live
// BEHAVIOUR
// - Reset values:
//   - req_ready=0, tx_c0_rdvalid=0, tx_c0_header=0, rsp_valid=0, rsp_addr=0, rsp_data=0, outst_cnt=0, err_unexp_rsp=0.
//   - All tags become free. RR pointer=0.
// - Grant eligibility in cycle t requires all of: !reset, !tx_c0_almostfull, at least one free tag.
//   - When eligible, req_ready is one-hot (combinational): the first asserted req_valid at or after the RR pointer, with wrap-around.
// - RR pointer update: on a grant to requester i, the pointer becomes (i+1) mod NUM_REQ. With no grant it holds.
// - Tag choice: the lowest-index free tag. The tag entry records requester id and address, and becomes live.
// - Issue (1-cycle latency): in cycle t+1, tx_c0_rdvalid=1 and the header is:
//   - [55:52] = RD_REQ_TYPE
//   - [45:14] = address
//   - [13:0]  = tag, zero-extended
//   - all other bits 0
// - When no read is issued, tx_c0_rdvalid=0 and tx_c0_header holds its last value.
// - At most one read is issued per cycle.
// - Response (1-cycle latency): rx_c0_rdvalid with a live tag (= mdata[$clog2(MAX_OUTST)-1:0], upper mdata bits 0) does the following next cycle:
//   - rsp_valid[owner]=1, rsp_addr=entry address, rsp_data=rx_c0_data.
//   - The tag is freed at that edge and can be allocated in the cycle after.
// - Unexpected response: a response whose tag is not live, or whose upper mdata bits are non-zero, causes:
//   - no rsp_valid
//   - err_unexp_rsp=1 for one cycle
//   - no state change
// - outst_cnt: +1 on allocate, -1 on free; unchanged when both happen in the same cycle. It never exceeds MAX_OUTST.
// - Full: when outst_cnt==MAX_OUTST, all req_ready are 0 even if tx_c0_almostfull=0.
// - Reset mid-operation: all tags are cleared. Responses arriving after reset find no live tag and pulse err_unexp_rsp.
// CONFIGURATION
// - Macro CCI_RD_ARB_HAZARD_CHK_EN, when defined:
//   - A requester whose req_addr equals the address of any live tag is masked from arbitration until that tag frees.
//   - The RR pointer skips masked requesters.
//   - Extra output hazard_stall_cnt (32 bits, reset 0, saturating) increments every cycle in which at least one valid requester is masked.
// - Macro not defined: no address compare, no masking, and the hazard_stall_cnt port is absent.
// TESTING
// - Reset, then req_valid=4'b1111 held for 4 cycles with almostfull=0:
//   - grants go to 0,1,2,3 in order
//   - tx_c0_rdvalid on 4 consecutive cycles with mdata tags 0,1,2,3
// - Issue 16 reads with no responses:
//   - outst_cnt=16, then req_ready=0
//   - a response with tag 5 gives rsp_valid for the owner 1 cycle later and outst_cnt=15
//   - the next grant gets tag 5
// - Assert tx_c0_almostfull=1 while req_valid=4'b0010: no req_ready and no tx_c0_rdvalid. Drop it: grant to requester 1 on the same cycle.
// - rx_c0_rdvalid with mdata=14'h0009 while tag 9 is free: err_unexp_rsp pulses once, rsp_valid stays 0, outst_cnt is unchanged.
// - Allocate and free in the same cycle: outst_cnt is unchanged. Reset with 3 tags live, then a response for tag 1: err_unexp_rsp=1.
// - With CCI_RD_ARB_HAZARD_CHK_EN:
//   - requester 0 reads addr 0x100 (live), then requester 2 requests 0x100: it is stalled and hazard_stall_cnt increments
//   - after the response it is granted

Source files
------------

// File: rtl/cci_rd_arbiter.sv
// Round-robin CCI TX0 read arbiter with tag table and RX0 response routing.
// Optional address-hazard masking: CCI_RD_ARB_HAZARD_CHK_EN.
module cci_rd_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         MAX_OUTST    = 16,
    parameter int         TX_HDR_WIDTH = 61,
    parameter int         RX_HDR_WIDTH = 18,
    parameter int         DATA_WIDTH   = 512,
    parameter int         CLADDR_WIDTH = 32,
    parameter logic [3:0] RD_REQ_TYPE  = 4'h4,
    localparam int        TW           = $clog2(MAX_OUTST),
    localparam int        CW           = TW + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*CLADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            tx_c0_almostfull,
    output logic [TX_HDR_WIDTH-1:0]         tx_c0_header,
    output logic                            tx_c0_rdvalid,
    input  logic [RX_HDR_WIDTH-1:0]         rx_c0_header,
    input  logic [DATA_WIDTH-1:0]           rx_c0_data,
    input  logic                            rx_c0_rdvalid,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [CLADDR_WIDTH-1:0]         rsp_addr,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic [CW-1:0]                   outst_cnt,
    output logic                            err_unexp_rsp
`ifdef CCI_RD_ARB_HAZARD_CHK_EN
    ,
    output logic [31:0]                     hazard_stall_cnt
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int MW = 14;

    logic [MAX_OUTST-1:0]    tag_live;
    logic [PW-1:0]           tag_owner [MAX_OUTST];
    logic [CLADDR_WIDTH-1:0] tag_addr  [MAX_OUTST];
    logic [PW-1:0]           rr_ptr;

    logic [TW-1:0]           free_tag;
    logic                    tag_avail;
    logic [NUM_REQ-1:0]      cand;
    logic [PW-1:0]           gnt_id;
    logic                    gnt_found;
    logic                    grant;
    int                      arb_idx;
    logic [CLADDR_WIDTH-1:0] gnt_addr;
    logic [TX_HDR_WIDTH-1:0] issue_hdr;
    logic [TW-1:0]           rx_tag;
    logic                    rx_hit;
    logic                    unused_hdr;

    assign unused_hdr = ^rx_c0_header[RX_HDR_WIDTH-1:MW];

`ifdef CCI_RD_ARB_HAZARD_CHK_EN
    logic [NUM_REQ-1:0] hz_mask;

    // A requester hitting any live tag's address waits until that tag frees
    always_comb begin
        hz_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int t = 0; t < MAX_OUTST; t++)
                if (tag_live[t] &&
                    tag_addr[t] == req_addr[i*CLADDR_WIDTH +: CLADDR_WIDTH])
                    hz_mask[i] = 1'b1;
    end

    assign cand = req_valid & ~hz_mask;

    always_ff @(posedge clk) begin
        if (reset)
            hazard_stall_cnt <= '0;
        else if (|(req_valid & hz_mask) && hazard_stall_cnt != '1)
            hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
    end
`else
    assign cand = req_valid;
`endif

    always_comb begin
        free_tag = '0;
        for (int t = MAX_OUTST - 1; t >= 0; t--)
            if (!tag_live[t]) free_tag = TW'(t);
    end

    assign tag_avail = ~&tag_live;

    // Scan downward so the nearest candidate at/after rr_ptr wins last
    always_comb begin
        gnt_id    = '0;
        gnt_found = 1'b0;
        arb_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (cand[arb_idx[PW-1:0]]) begin
                gnt_id    = arb_idx[PW-1:0];
                gnt_found = 1'b1;
            end
        end
    end

    assign grant = !reset && !tx_c0_almostfull && tag_avail && gnt_found;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_id] = 1'b1;
    end

    assign gnt_addr = req_addr[int'(gnt_id)*CLADDR_WIDTH +: CLADDR_WIDTH];

    always_comb begin
        issue_hdr = '0;
        issue_hdr[55:52] = RD_REQ_TYPE;
        issue_hdr[MW +: CLADDR_WIDTH] = gnt_addr;
        issue_hdr[TW-1:0] = free_tag;
    end

    assign rx_tag = rx_c0_header[TW-1:0];
    assign rx_hit = rx_c0_rdvalid && (rx_c0_header[MW-1:TW] == '0) &&
                    tag_live[rx_tag];

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_owner[free_tag] <= gnt_id;
            tag_addr[free_tag]  <= gnt_addr;
        end
    end

    // A freed tag is still live this cycle, so free_tag never equals rx_tag
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_live      <= '0;
            rr_ptr        <= '0;
            outst_cnt     <= '0;
            tx_c0_rdvalid <= 1'b0;
            tx_c0_header  <= '0;
            rsp_valid     <= '0;
            rsp_addr      <= '0;
            rsp_data      <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            tx_c0_rdvalid <= grant;
            rsp_valid     <= '0;
            err_unexp_rsp <= rx_c0_rdvalid && !rx_hit;
            if (grant) begin
                tx_c0_header       <= issue_hdr;
                tag_live[free_tag] <= 1'b1;
                rr_ptr <= (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (rx_hit) begin
                tag_live[rx_tag]             <= 1'b0;
                rsp_valid[tag_owner[rx_tag]] <= 1'b1;
                rsp_addr                     <= tag_addr[rx_tag];
                rsp_data                     <= rx_c0_data;
            end
            outst_cnt <= outst_cnt + CW'(grant) - CW'(rx_hit);
        end
    end

endmodule
